master_interface: RTL and testbench

MASTER_INTERFACE -- requirements
Module: master_interface

---
 rtl/master_interface_pkg.sv | 18 +
 rtl/master_interface_if.sv | 36 +++
 rtl/slave_interface.sv | 153 +++++++++++++++
 rtl/master_interface.sv | 156 +++++++++++++++
 tb/tb_master_interface.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/master_interface_pkg.sv
// Shared definitions for the master_interface block and its companion
// slave_interface: default bus width, register-file geometry and the
// state encodings of every FSM on both sides of the bus.
package master_interface_pkg;

  localparam int REG_WIDTH_DEF = 32;
  localparam int REG_DEPTH     = 16;
  localparam int IDX_W         = 4;

  // Master read / write FSMs
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} m_rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} m_wr_state_e;

  // Slave read / write FSMs
  typedef enum logic {SR_IDLE, SR_DATA} s_rd_state_e;
  typedef enum logic {SW_IDLE, SW_RESP} s_wr_state_e;

endpackage

// File: rtl/master_interface_if.sv
// Bus bundle between master_interface and slave_interface: read address,
// read data, write address, write data and write response channels.
// Modports:
//   master - drives ARADDR/ARVALID/RREADY/AWADDR/AWVALID/WDATA/WVALID/BREADY
//   slave  - drives ARREADY/RDATA/RVALID/AWREADY/WREADY/BVALID
interface master_interface_if #(
  parameter int REG_WIDTH = master_interface_pkg::REG_WIDTH_DEF
);
  import master_interface_pkg::*;

  logic [REG_WIDTH-1:0] ARADDR;
  logic                 ARVALID;
  logic                 ARREADY;
  logic [REG_WIDTH-1:0] RDATA;
  logic                 RVALID;
  logic                 RREADY;
  logic [REG_WIDTH-1:0] AWADDR;
  logic                 AWVALID;
  logic                 AWREADY;
  logic [REG_WIDTH-1:0] WDATA;
  logic                 WVALID;
  logic                 WREADY;
  logic                 BVALID;
  logic                 BREADY;

  modport master (
    output ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WVALID, BREADY,
    input  ARREADY, RDATA, RVALID, AWREADY, WREADY, BVALID
  );

  modport slave (
    input  ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WVALID, BREADY,
    output ARREADY, RDATA, RVALID, AWREADY, WREADY, BVALID
  );

endinterface

// File: rtl/slave_interface.sv
// Companion slave: a 16-entry register file behind the bus channels.
// Ports:
//   ACLK    - clock, rising edge
//   ARESETN - asynchronous reset, active-high
//   bus     - slave side of master_interface_if
// Readies are registered: 0 in reset, 1 whenever the channel is idle.
// A read and a write hitting the same index on one edge return the old
// value, because the read samples the array on the edge that writes it.
module slave_interface
  import master_interface_pkg::*;
#(
  parameter int REG_WIDTH = REG_WIDTH_DEF
) (
  input logic               ACLK,
  input logic               ARESETN,
  master_interface_if.slave bus
);

  logic [REG_WIDTH-1:0] regs [REG_DEPTH];

  s_rd_state_e          sr_q, sr_n;
  logic                 arready_q, arready_n;
  logic                 rvalid_q, rvalid_n;
  logic [REG_WIDTH-1:0] rdata_q, rdata_n;

  s_wr_state_e          sw_q, sw_n;
  logic                 awready_q, awready_n;
  logic                 wready_q, wready_n;
  logic                 bvalid_q, bvalid_n;
  logic                 aw_got_q, aw_got_n;
  logic                 w_got_q, w_got_n;
  logic [IDX_W-1:0]     awidx_q, awidx_n;
  logic [REG_WIDTH-1:0] wdata_q, wdata_n;
  logic                 we;
  logic [IDX_W-1:0]     w_idx;
  logic [REG_WIDTH-1:0] w_val;

  assign bus.ARREADY = arready_q;
  assign bus.RVALID  = rvalid_q;
  assign bus.RDATA   = rdata_q;
  assign bus.AWREADY = awready_q;
  assign bus.WREADY  = wready_q;
  assign bus.BVALID  = bvalid_q;

  always_comb begin
    sr_n      = sr_q;
    arready_n = arready_q;
    rvalid_n  = rvalid_q;
    rdata_n   = rdata_q;
    unique case (sr_q)
      SR_IDLE: begin
        arready_n = 1'b1;
        if (bus.ARVALID && arready_q) begin
          arready_n = 1'b0;
          rvalid_n  = 1'b1;
          rdata_n   = regs[bus.ARADDR[IDX_W-1:0]];
          sr_n      = SR_DATA;
        end
      end
      SR_DATA: begin
        if (rvalid_q && bus.RREADY) begin
          rvalid_n  = 1'b0;
          arready_n = 1'b1;
          sr_n      = SR_IDLE;
        end
      end
      default: sr_n = SR_IDLE;
    endcase
  end

  // Address and data are collected independently; the array is written on
  // the edge where the second of the two arrives.
  always_comb begin
    sw_n      = sw_q;
    awready_n = awready_q;
    wready_n  = wready_q;
    bvalid_n  = bvalid_q;
    aw_got_n  = aw_got_q;
    w_got_n   = w_got_q;
    awidx_n   = awidx_q;
    wdata_n   = wdata_q;
    we        = 1'b0;
    w_idx     = '0;
    w_val     = '0;
    unique case (sw_q)
      SW_IDLE: begin
        if (bus.AWVALID && awready_q) begin
          aw_got_n = 1'b1;
          awidx_n  = bus.AWADDR[IDX_W-1:0];
        end
        if (bus.WVALID && wready_q) begin
          w_got_n = 1'b1;
          wdata_n = bus.WDATA;
        end
        awready_n = !aw_got_n;
        wready_n  = !w_got_n;
        if (aw_got_n && w_got_n) begin
          we        = 1'b1;
          w_idx     = awidx_n;
          w_val     = wdata_n;
          bvalid_n  = 1'b1;
          aw_got_n  = 1'b0;
          w_got_n   = 1'b0;
          awready_n = 1'b0;
          wready_n  = 1'b0;
          sw_n      = SW_RESP;
        end
      end
      SW_RESP: begin
        if (bvalid_q && bus.BREADY) begin
          bvalid_n  = 1'b0;
          awready_n = 1'b1;
          wready_n  = 1'b1;
          sw_n      = SW_IDLE;
        end
      end
      default: sw_n = SW_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESETN) begin
    if (ARESETN) begin
      sr_q      <= SR_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      sw_q      <= SW_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
    end else begin
      sr_q      <= sr_n;
      arready_q <= arready_n;
      rvalid_q  <= rvalid_n;
      rdata_q   <= rdata_n;
      sw_q      <= sw_n;
      awready_q <= awready_n;
      wready_q  <= wready_n;
      bvalid_q  <= bvalid_n;
      aw_got_q  <= aw_got_n;
      w_got_q   <= w_got_n;
      awidx_q   <= awidx_n;
      wdata_q   <= wdata_n;
      if (we) regs[w_idx] <= w_val;
    end
  end

endmodule

// File: rtl/master_interface.sv
// Bus master: turns simple module-side read and write requests into
// handshaked channel transactions. The read and write FSMs are fully
// independent and may run concurrently.
// Ports:
//   ACLK, ARESETN            - clock (rising edge), async active-high reset
//   MOD_2_M_RRQST/RADDR      - read request and address
//   M_2_MOD_RDATA            - data of the last completed read (held)
//   MOD_2_M_WARQST/WADDR     - write address request
//   MOD_2_M_WRQST/WDATA      - write data request
//   M_2_MOD_WRESULT          - one-cycle pulse when a write response arrives
//   bus                      - master side of master_interface_if
module master_interface
  import master_interface_pkg::*;
#(
  parameter int REG_WIDTH = REG_WIDTH_DEF
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 MOD_2_M_RRQST,
  input  logic [REG_WIDTH-1:0] MOD_2_M_RADDR,
  output logic [REG_WIDTH-1:0] M_2_MOD_RDATA,
  input  logic                 MOD_2_M_WARQST,
  input  logic [REG_WIDTH-1:0] MOD_2_M_WADDR,
  input  logic                 MOD_2_M_WRQST,
  input  logic [REG_WIDTH-1:0] MOD_2_M_WDATA,
  output logic                 M_2_MOD_WRESULT,
  master_interface_if.master   bus
);

  m_rd_state_e          r_state_q, r_state_n;
  logic [REG_WIDTH-1:0] araddr_q, araddr_n;
  logic                 arvalid_q, arvalid_n;
  logic                 rready_q, rready_n;
  logic [REG_WIDTH-1:0] rdata_q, rdata_n;

  m_wr_state_e          w_state_q, w_state_n;
  logic [REG_WIDTH-1:0] awaddr_q, awaddr_n;
  logic                 awvalid_q, awvalid_n;
  logic [REG_WIDTH-1:0] wdata_q, wdata_n;
  logic                 wvalid_q, wvalid_n;
  logic                 bready_q, bready_n;
  logic                 wresult_q, wresult_n;

  assign bus.ARADDR      = araddr_q;
  assign bus.ARVALID     = arvalid_q;
  assign bus.RREADY      = rready_q;
  assign bus.AWADDR      = awaddr_q;
  assign bus.AWVALID     = awvalid_q;
  assign bus.WDATA       = wdata_q;
  assign bus.WVALID      = wvalid_q;
  assign bus.BREADY      = bready_q;
  assign M_2_MOD_RDATA   = rdata_q;
  assign M_2_MOD_WRESULT = wresult_q;

  always_comb begin
    r_state_n = r_state_q;
    araddr_n  = araddr_q;
    arvalid_n = arvalid_q;
    rready_n  = rready_q;
    rdata_n   = rdata_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (MOD_2_M_RRQST) begin
          araddr_n  = MOD_2_M_RADDR;
          arvalid_n = 1'b1;
          r_state_n = R_ADDR;
        end
      end
      R_ADDR: begin
        if (arvalid_q && bus.ARREADY) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          r_state_n = R_DATA;
        end
      end
      R_DATA: begin
        if (rready_q && bus.RVALID) begin
          rdata_n   = bus.RDATA;
          rready_n  = 1'b0;
          r_state_n = R_IDLE;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  // Address and data channels retire independently; the response phase
  // starts only once both valids have been accepted.
  always_comb begin
    w_state_n = w_state_q;
    awaddr_n  = awaddr_q;
    awvalid_n = awvalid_q;
    wdata_n   = wdata_q;
    wvalid_n  = wvalid_q;
    bready_n  = bready_q;
    wresult_n = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (MOD_2_M_WARQST && MOD_2_M_WRQST) begin
          awaddr_n  = MOD_2_M_WADDR;
          wdata_n   = MOD_2_M_WDATA;
          awvalid_n = 1'b1;
          wvalid_n  = 1'b1;
          w_state_n = W_XFER;
        end
      end
      W_XFER: begin
        if (awvalid_q && bus.AWREADY) awvalid_n = 1'b0;
        if (wvalid_q && bus.WREADY)   wvalid_n  = 1'b0;
        if (!awvalid_n && !wvalid_n) begin
          bready_n  = 1'b1;
          w_state_n = W_RESP;
        end
      end
      W_RESP: begin
        if (bready_q && bus.BVALID) begin
          bready_n  = 1'b0;
          wresult_n = 1'b1;
          w_state_n = W_IDLE;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESETN) begin
    if (ARESETN) begin
      r_state_q <= R_IDLE;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rdata_q   <= '0;
      w_state_q <= W_IDLE;
      awaddr_q  <= '0;
      awvalid_q <= 1'b0;
      wdata_q   <= '0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      wresult_q <= 1'b0;
    end else begin
      r_state_q <= r_state_n;
      araddr_q  <= araddr_n;
      arvalid_q <= arvalid_n;
      rready_q  <= rready_n;
      rdata_q   <= rdata_n;
      w_state_q <= w_state_n;
      awaddr_q  <= awaddr_n;
      awvalid_q <= awvalid_n;
      wdata_q   <= wdata_n;
      wvalid_q  <= wvalid_n;
      bready_q  <= bready_n;
      wresult_q <= wresult_n;
    end
  end

endmodule

// File: tb/tb_master_interface.sv
// Directed bench: master_interface talking to slave_interface through two
// interface instances joined by the bench. hold_ar / hold_w let the bench
// stall the AR or W channel without the slave seeing the request.
module tb_master_interface;

  logic        ACLK;
  logic        ARESETN;
  logic        rrqst;
  logic [31:0] raddr;
  logic [31:0] rdata_out;
  logic        warqst;
  logic [31:0] waddr;
  logic        wrqst;
  logic [31:0] wdata;
  logic        wresult;
  logic        hold_ar;
  logic        hold_w;

  int vectors;
  int miscompares;

  master_interface_if #(.REG_WIDTH(32)) m_if ();
  master_interface_if #(.REG_WIDTH(32)) s_if ();

  assign s_if.ARADDR  = m_if.ARADDR;
  assign s_if.ARVALID = m_if.ARVALID & ~hold_ar;
  assign s_if.RREADY  = m_if.RREADY;
  assign s_if.AWADDR  = m_if.AWADDR;
  assign s_if.AWVALID = m_if.AWVALID;
  assign s_if.WDATA   = m_if.WDATA;
  assign s_if.WVALID  = m_if.WVALID & ~hold_w;
  assign s_if.BREADY  = m_if.BREADY;
  assign m_if.ARREADY = s_if.ARREADY & ~hold_ar;
  assign m_if.RDATA   = s_if.RDATA;
  assign m_if.RVALID  = s_if.RVALID;
  assign m_if.AWREADY = s_if.AWREADY;
  assign m_if.WREADY  = s_if.WREADY & ~hold_w;
  assign m_if.BVALID  = s_if.BVALID;

  master_interface #(.REG_WIDTH(32)) u_dut (
    .ACLK            (ACLK),
    .ARESETN         (ARESETN),
    .MOD_2_M_RRQST   (rrqst),
    .MOD_2_M_RADDR   (raddr),
    .M_2_MOD_RDATA   (rdata_out),
    .MOD_2_M_WARQST  (warqst),
    .MOD_2_M_WADDR   (waddr),
    .MOD_2_M_WRQST   (wrqst),
    .MOD_2_M_WDATA   (wdata),
    .M_2_MOD_WRESULT (wresult),
    .bus             (m_if)
  );

  slave_interface #(.REG_WIDTH(32)) u_slv (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .bus     (s_if)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_master_zero(input string tag);
    chk ({tag, ".araddr"},  m_if.ARADDR,  32'h0);
    chk1({tag, ".arvalid"}, m_if.ARVALID, 1'b0);
    chk1({tag, ".rready"},  m_if.RREADY,  1'b0);
    chk ({tag, ".rdata"},   rdata_out,    32'h0);
    chk ({tag, ".awaddr"},  m_if.AWADDR,  32'h0);
    chk1({tag, ".awvalid"}, m_if.AWVALID, 1'b0);
    chk ({tag, ".wdata"},   m_if.WDATA,   32'h0);
    chk1({tag, ".wvalid"},  m_if.WVALID,  1'b0);
    chk1({tag, ".bready"},  m_if.BREADY,  1'b0);
    chk1({tag, ".wresult"}, wresult,      1'b0);
  endtask

  // Complete read: request sampled on edge 1, AR handshake on edge 2,
  // data captured on edge 3.
  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    rrqst = 1'b1; raddr = addr;
    tick();
    rrqst = 1'b0;
    chk1({tag, ".arvalid1"}, m_if.ARVALID, 1'b1);
    chk ({tag, ".araddr"},   m_if.ARADDR,  addr);
    chk1({tag, ".rready1"},  m_if.RREADY,  1'b0);
    tick();
    chk1({tag, ".arvalid2"}, m_if.ARVALID, 1'b0);
    chk1({tag, ".rready2"},  m_if.RREADY,  1'b1);
    tick();
    chk1({tag, ".rready3"},  m_if.RREADY,  1'b0);
    chk ({tag, ".rdata"},    rdata_out,    exp);
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] dat);
    warqst = 1'b1; wrqst = 1'b1; waddr = addr; wdata = dat;
    tick();
    warqst = 1'b0; wrqst = 1'b0;
    chk1({tag, ".awvalid1"}, m_if.AWVALID, 1'b1);
    chk1({tag, ".wvalid1"},  m_if.WVALID,  1'b1);
    chk ({tag, ".awaddr"},   m_if.AWADDR,  addr);
    chk ({tag, ".wdata"},    m_if.WDATA,   dat);
    tick();
    chk1({tag, ".awvalid2"}, m_if.AWVALID, 1'b0);
    chk1({tag, ".wvalid2"},  m_if.WVALID,  1'b0);
    chk1({tag, ".bready2"},  m_if.BREADY,  1'b1);
    chk1({tag, ".wresult2"}, wresult,      1'b0);
    tick();
    chk1({tag, ".bready3"},  m_if.BREADY,  1'b0);
    chk1({tag, ".wresult3"}, wresult,      1'b1);
    tick();
    chk1({tag, ".wresult4"}, wresult,      1'b0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    ARESETN = 1'b1;
    rrqst = 1'b0; raddr = '0;
    warqst = 1'b0; waddr = '0; wrqst = 1'b0; wdata = '0;
    hold_ar = 1'b0; hold_w = 1'b0;

    // Reset state
    tick(); tick();
    chk_master_zero("reset");
    chk1("reset.s_arready", s_if.ARREADY, 1'b0);
    chk1("reset.s_awready", s_if.AWREADY, 1'b0);
    chk1("reset.s_wready",  s_if.WREADY,  1'b0);
    for (int i = 0; i < 16; i++) chk($sformatf("reset.reg%0d", i), u_slv.regs[i], 32'h0);
    ARESETN = 1'b0;
    tick();
    chk1("idle.s_arready", s_if.ARREADY, 1'b1);
    chk1("idle.s_awready", s_if.AWREADY, 1'b1);

    // Read 15 after reset
    do_read("rd15", 32'd15, 32'h0);

    // Address request alone must not start a write
    warqst = 1'b1; waddr = 32'd10;
    tick();
    chk1("wa_only.awvalid", m_if.AWVALID, 1'b0);
    warqst = 1'b0;

    // Write 10 <- 0x2564, then read it back and check it holds
    do_write("wr10", 32'd10, 32'h2564);
    chk("wr10.reg", u_slv.regs[10], 32'h2564);
    do_read("rd10", 32'd10, 32'h2564);
    tick(); tick(); tick();
    chk("rd10.hold", rdata_out, 32'h2564);

    // Request left high restarts immediately; second read latches new address
    rrqst = 1'b1; raddr = 32'd10;
    tick(); tick(); tick();
    chk1("b2b.rready", m_if.RREADY, 1'b0);
    chk ("b2b.rdata1", rdata_out, 32'h2564);
    raddr = 32'd15;
    tick();
    rrqst = 1'b0;
    chk1("b2b.arvalid", m_if.ARVALID, 1'b1);
    chk ("b2b.araddr",  m_if.ARADDR,  32'd15);
    tick(); tick();
    chk ("b2b.rdata2", rdata_out, 32'h0);

    // AR stalled 3 cycles: ARVALID/ARADDR stable while the request input moves
    hold_ar = 1'b1;
    rrqst = 1'b1; raddr = 32'd10;
    tick();
    rrqst = 1'b0; raddr = 32'd3;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk1($sformatf("stall.arvalid%0d", c), m_if.ARVALID, 1'b1);
      chk ($sformatf("stall.araddr%0d", c),  m_if.ARADDR,  32'd10);
    end
    hold_ar = 1'b0;
    tick();
    chk1("stall.arvalid_done", m_if.ARVALID, 1'b0);
    chk1("stall.rready",       m_if.RREADY,  1'b1);
    tick();
    chk ("stall.rdata", rdata_out, 32'h2564);

    // W channel late: AW retires first, response waits for W
    hold_w = 1'b1;
    warqst = 1'b1; wrqst = 1'b1; waddr = 32'd7; wdata = 32'h55AA;
    tick();
    warqst = 1'b0; wrqst = 1'b0;
    tick();
    chk1("split.awvalid", m_if.AWVALID, 1'b0);
    chk1("split.wvalid",  m_if.WVALID,  1'b1);
    chk1("split.bready",  m_if.BREADY,  1'b0);
    hold_w = 1'b0;
    tick();
    chk1("split.wvalid2", m_if.WVALID, 1'b0);
    chk1("split.bready2", m_if.BREADY, 1'b1);
    tick();
    chk1("split.wresult", wresult, 1'b1);
    chk ("split.reg7", u_slv.regs[7], 32'h55AA);

    // Concurrent read 15 / write 10
    rrqst = 1'b1; raddr = 32'd15;
    warqst = 1'b1; wrqst = 1'b1; waddr = 32'd10; wdata = 32'hBEEF;
    tick();
    rrqst = 1'b0; warqst = 1'b0; wrqst = 1'b0;
    chk1("conc.arvalid", m_if.ARVALID, 1'b1);
    chk1("conc.awvalid", m_if.AWVALID, 1'b1);
    tick();
    chk1("conc.rready", m_if.RREADY, 1'b1);
    chk1("conc.bready", m_if.BREADY, 1'b1);
    tick();
    chk ("conc.rdata",   rdata_out, 32'h0);
    chk1("conc.wresult", wresult,   1'b1);
    chk ("conc.reg10",   u_slv.regs[10], 32'hBEEF);

    // Same-index read and write on one edge returns the old value
    rrqst = 1'b1; raddr = 32'd7;
    warqst = 1'b1; wrqst = 1'b1; waddr = 32'd7; wdata = 32'h0F0F;
    tick();
    rrqst = 1'b0; warqst = 1'b0; wrqst = 1'b0;
    tick(); tick();
    chk("same.rdata", rdata_out, 32'h55AA);
    chk("same.reg7",  u_slv.regs[7], 32'h0F0F);
    tick();

    // Reset during W_RESP: asynchronous clear, no completion pulse
    warqst = 1'b1; wrqst = 1'b1; waddr = 32'd5; wdata = 32'h1234;
    tick();
    warqst = 1'b0; wrqst = 1'b0;
    tick();
    chk1("abort.bready", m_if.BREADY, 1'b1);
    ARESETN = 1'b1;
    #2;
    chk_master_zero("abort");
    chk("abort.reg10", u_slv.regs[10], 32'h0);
    tick();
    chk1("abort.wresult_rst", wresult, 1'b0);
    ARESETN = 1'b0;
    tick(); tick();
    chk1("abort.wresult_post", wresult, 1'b0);
    chk1("abort.awvalid_post", m_if.AWVALID, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
